// File: rtl/osd_wr_scheduler_pkg.sv
// Shared OSD write-path definitions: CPU write-vector field layout and scheduler state encoding.
// Used by the controller that builds wr_vec and by osd_wr_scheduler.
package osd_wr_scheduler_pkg;

  localparam int OSD_ADDR_W  = 11;
  localparam int OSD_DATA_W  = 12;

  // wr_vec = {req_tgl, sel, addr, data}
  localparam int WR_DATA_LSB = 0;
  localparam int WR_ADDR_LSB = OSD_DATA_W;
  localparam int WR_SEL_BIT  = OSD_ADDR_W + OSD_DATA_W;
  localparam int WR_REQ_BIT  = WR_SEL_BIT + 1;
  localparam int WR_VEC_W    = WR_REQ_BIT + 1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_VBLANK = 2'd1,
    ST_HSYNC  = 2'd2
  } osd_wr_state_e;

endpackage

// File: rtl/osd_wr_fifo.sv
// Synchronous request FIFO with registered full/empty flags and an occupancy level.
// Pushes while full and pops while empty are ignored.
module osd_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                     N64_CLK_i,
  input  logic                     CTRL_nRST,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level_nx;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_nx = level;
    if (do_push && !do_pop)
      level_nx = level + (PW+1)'(1);
    else if (!do_push && do_pop)
      level_nx = level - (PW+1)'(1);
  end

  // Flags are derived from the next level so they are valid straight from a flop.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nx;
      full  <= (level_nx == (PW+1)'(DEPTH));
      empty <= (level_nx == '0);
    end
  end

  always_ff @(posedge N64_CLK_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/osd_wr_scheduler.sv
// Moves CPU OSD write requests into the OSD RAM write port, releasing them only in video blanking.
// Optional OSD_HBLANK_WR_EN also opens the write window during each hsync pulse.
module osd_wr_scheduler
  import osd_wr_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int VBLANK_LINES = 16,
  parameter int ADDR_W       = OSD_ADDR_W,
  parameter int DATA_W       = OSD_DATA_W
) (
  input  logic                          N64_CLK_i,
  input  logic                          CTRL_nRST,
  input  logic                          nVDSYNC_i,
  input  logic                          VD_VS_i,
  input  logic                          VD_HS_i,
  input  logic [WR_VEC_W-1:0]           wr_vec_i,
  output logic                          wr_ack_tgl_o,
  output logic                          ram_we_o,
  output logic                          ram_sel_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [DATA_W-1:0]             ram_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
  output logic                          win_open_o,
  output osd_wr_state_e                 fsm_state_o
);

  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam int LC_W  = $clog2(VBLANK_LINES + 1);

  logic vs_buf, hs_buf, vs_prev, hs_prev;
  logic vs_fall, hs_fall;

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      vs_buf  <= 1'b1;
      hs_buf  <= 1'b1;
      vs_prev <= 1'b1;
      hs_prev <= 1'b1;
    end else begin
      if (!nVDSYNC_i) begin
        vs_buf <= VD_VS_i;
        hs_buf <= VD_HS_i;
      end
      vs_prev <= vs_buf;
      hs_prev <= hs_buf;
    end
  end

  assign vs_fall = vs_prev & ~vs_buf;
  assign hs_fall = hs_prev & ~hs_buf;

  // Handshake: the CPU flips req_tgl with {sel,addr,data} stable and holds it until
  // wr_ack_tgl_o flips to match; one flip of each side is exactly one request.
  logic       req_s1, req_s2, req_prev;
  logic [1:0] arm_cnt;
  logic       armed, take;
  logic       fifo_full, fifo_empty, pop;
  logic [ENT_W-1:0] fifo_din, fifo_dout;

  assign armed    = (arm_cnt == 2'd3);
  assign take     = armed && (req_s2 != req_prev) && !fifo_full;
  assign fifo_din = {wr_vec_i[WR_SEL_BIT],
                     wr_vec_i[WR_ADDR_LSB +: ADDR_W],
                     wr_vec_i[WR_DATA_LSB +: DATA_W]};

  // Until armed, req_prev follows the synchroniser so a toggle left at 1 is not an edge.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      req_s1       <= 1'b0;
      req_s2       <= 1'b0;
      req_prev     <= 1'b0;
      arm_cnt      <= 2'd0;
      wr_ack_tgl_o <= 1'b0;
    end else begin
      req_s1 <= wr_vec_i[WR_REQ_BIT];
      req_s2 <= req_s1;
      if (!armed) begin
        arm_cnt  <= arm_cnt + 2'd1;
        req_prev <= req_s2;
      end else if (take) begin
        req_prev     <= req_s2;
        wr_ack_tgl_o <= ~wr_ack_tgl_o;
      end
    end
  end

  osd_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .N64_CLK_i (N64_CLK_i),
    .CTRL_nRST (CTRL_nRST),
    .push      (take),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_lvl_o)
  );

  osd_wr_state_e   state, state_nx;
  logic [LC_W-1:0] line_cnt, line_cnt_nx;

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state    <= ST_ACTIVE;
      line_cnt <= '0;
    end else begin
      state    <= state_nx;
      line_cnt <= line_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    line_cnt_nx = line_cnt;
    case (state)
      ST_ACTIVE: begin
        if (vs_fall) begin
          state_nx    = ST_VBLANK;
          line_cnt_nx = '0;
        end
`ifdef OSD_HBLANK_WR_EN
        else if (hs_fall) begin
          state_nx = ST_HSYNC;
        end
`endif
      end
      ST_VBLANK: begin
        if (vs_fall) begin
          line_cnt_nx = '0;
        end else if (hs_fall) begin
          if (line_cnt == LC_W'(VBLANK_LINES - 1))
            state_nx = ST_ACTIVE;
          else
            line_cnt_nx = line_cnt + LC_W'(1);
        end
      end
`ifdef OSD_HBLANK_WR_EN
      ST_HSYNC: begin
        if (vs_fall) begin
          state_nx    = ST_VBLANK;
          line_cnt_nx = '0;
        end else if (hs_buf) begin
          state_nx = ST_ACTIVE;
        end
      end
`endif
      default: state_nx = ST_ACTIVE;
    endcase
  end

  assign win_open_o  = (state != ST_ACTIVE);
  assign fsm_state_o = state;
  assign pop         = win_open_o && !fifo_empty;

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      ram_we_o   <= 1'b0;
      ram_sel_o  <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      ram_we_o <= pop;
      if (pop) {ram_sel_o, ram_addr_o, ram_data_o} <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_osd_wr_scheduler.sv
// Bench for osd_wr_scheduler: random requests against a queue/line-count model of the write window.
// Build with or without OSD_HBLANK_WR_EN; expectations follow the macro.
module tb_osd_wr_scheduler;
  import osd_wr_scheduler_pkg::*;

  localparam int FIFO_DEPTH   = 8;
  localparam int VBLANK_LINES = 16;
  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 12;
  localparam int ENT_W        = 1 + ADDR_W + DATA_W;
`ifdef OSD_HBLANK_WR_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 nvdsync = 1'b1;
  logic                 vs = 1'b1;
  logic                 hs = 1'b1;
  logic [WR_VEC_W-1:0]  wr_vec = '0;
  logic                 wr_ack_tgl_o;
  logic                 ram_we_o;
  logic                 ram_sel_o;
  logic [ADDR_W-1:0]    ram_addr_o;
  logic [DATA_W-1:0]    ram_data_o;
  logic [3:0]           fifo_lvl_o;
  logic                 win_open_o;
  osd_wr_state_e        fsm_state_o;

  osd_wr_scheduler #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .VBLANK_LINES (VBLANK_LINES),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W)
  ) dut (
    .N64_CLK_i    (clk),
    .CTRL_nRST    (rst_n),
    .nVDSYNC_i    (nvdsync),
    .VD_VS_i      (vs),
    .VD_HS_i      (hs),
    .wr_vec_i     (wr_vec),
    .wr_ack_tgl_o (wr_ack_tgl_o),
    .ram_we_o     (ram_we_o),
    .ram_sel_o    (ram_sel_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .fifo_lvl_o   (fifo_lvl_o),
    .win_open_o   (win_open_o),
    .fsm_state_o  (fsm_state_o)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [ENT_W-1:0] exp_q[$];
  int  n_wr        = 0;
  int  acks_exp    = 0;
  int  vd_div      = 1;
  bit  model_vb    = 1'b0;
  int  model_lines = 0;
  bit  allow_wr    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ram_we_o) begin
      n_wr++;
      chk("wr_in_window", 32'(allow_wr), 32'd1);
      chk("wr_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        chk("wr_entry", {ram_sel_o, ram_addr_o, ram_data_o}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_cycle(input logic v, input logic h);
    for (int k = 0; k < vd_div; k++) begin
      nvdsync = (k != 0);
      vs = v;
      hs = h;
      tick();
    end
  endtask

  task automatic vsync();
    allow_wr    = 1'b1;
    model_vb    = 1'b1;
    model_lines = 0;
    sync_cycle(1'b0, 1'b1);
    sync_cycle(1'b0, 1'b1);
    sync_cycle(1'b1, 1'b1);
    sync_cycle(1'b1, 1'b1);
    chk("win_open_vs", 32'(win_open_o), 32'd1);
    chk("state_vblank", 32'(fsm_state_o), 32'(ST_VBLANK));
  endtask

  task automatic hs_line(input int low_len, input int high_len);
    bit was_vb;
    was_vb = model_vb;
    if (model_vb) begin
      model_lines++;
      if (model_lines == VBLANK_LINES) model_vb = 1'b0;
    end
    if (HB) allow_wr = 1'b1;
    for (int k = 0; k < low_len; k++) sync_cycle(1'b1, 1'b0);
    chk("win_in_hs", 32'(win_open_o), 32'(model_vb || (HB && !was_vb)));
    if (!HB && !model_vb) allow_wr = 1'b0;
    for (int k = 0; k < high_len; k++) sync_cycle(1'b1, 1'b1);
    if (!model_vb) allow_wr = 1'b0;
    chk("win_after_hs", 32'(win_open_o), 32'(model_vb));
  endtask

  task automatic frame(input int nlines);
    vsync();
    for (int i = 0; i < nlines; i++) hs_line(4, $urandom_range(8, 20));
  endtask

  task automatic issue_req(input logic [ENT_W-1:0] ent, input int max_wait, output int lat);
    wr_vec = {~wr_vec[WR_REQ_BIT], ent};
    exp_q.push_back(ent);
    acks_exp++;
    lat = 0;
    while (wr_ack_tgl_o != acks_exp[0] && lat < max_wait) begin
      tick();
      lat++;
    end
    chk("ack_level", 32'(wr_ack_tgl_o), 32'(acks_exp[0]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(wr_ack_tgl_o), 32'd0);
    chk({tag, "_we"},    32'(ram_we_o),     32'd0);
    chk({tag, "_sel"},   32'(ram_sel_o),    32'd0);
    chk({tag, "_addr"},  32'(ram_addr_o),   32'd0);
    chk({tag, "_data"},  32'(ram_data_o),   32'd0);
    chk({tag, "_lvl"},   32'(fifo_lvl_o),   32'd0);
    chk({tag, "_win"},   32'(win_open_o),   32'd0);
    chk({tag, "_state"}, 32'(fsm_state_o),  32'(ST_ACTIVE));
  endtask

  initial begin
    int lat;
    int wr0;
    logic [ENT_W-1:0] ent;

    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (5) tick();

    // single request, window closed until vsync
    ent = {1'b1, 11'h12A, 12'h0F3};
    issue_req(ent, 100, lat);
    chk("t1_ack_lat", lat, 3);
    chk("t1_lvl", 32'(fifo_lvl_o), 1);
    repeat (20) tick();
    chk("t1_no_wr_closed", n_wr, 0);
    frame(VBLANK_LINES);
    chk("t1_one_wr", n_wr, 1);
    chk("t1_drained", exp_q.size(), 0);

    // 9 back-to-back: the 9th waits for a pop
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      issue_req(ENT_W'($urandom), 100, lat);
      chk("t2_ack_lat", lat, 3);
      chk("t2_lvl", 32'(fifo_lvl_o), i + 1);
    end
    ent = ENT_W'($urandom);
    wr_vec = {~wr_vec[WR_REQ_BIT], ent};
    exp_q.push_back(ent);
    repeat (50) tick();
    chk("t2_ack_held_full", 32'(wr_ack_tgl_o), 32'(acks_exp[0]));
    chk("t2_lvl_full", 32'(fifo_lvl_o), FIFO_DEPTH);
    acks_exp++;
    fork
      frame(VBLANK_LINES);
      begin
        lat = 0;
        while (wr_ack_tgl_o != acks_exp[0] && lat < 4000) begin
          tick();
          lat++;
        end
        chk("t2_ack_after_pop", 32'(wr_ack_tgl_o), 32'(acks_exp[0]));
      end
    join
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_lvl_end", 32'(fifo_lvl_o), 0);

    // 20 random entries with refills while the window is open, sync valid 1 in 4
    vd_div = 4;
    wr0 = n_wr;
    fork
      frame(VBLANK_LINES);
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 10)) tick();
        issue_req(ENT_W'($urandom), 3000, lat);
      end
    join
    vd_div = 1;
    if (exp_q.size() != 0) frame(VBLANK_LINES);
    chk("t3_writes", n_wr - wr0, 20);
    chk("t3_drained", exp_q.size(), 0);

    // reset with 5 buffered and CPU toggle left at 1
    for (int i = 0; i < 5; i++) begin
      issue_req(ENT_W'($urandom), 100, lat);
      chk("t4_ack_lat", lat, 3);
    end
    chk("t4_lvl", 32'(fifo_lvl_o), 5);
    chk("t4_tgl_high", 32'(wr_vec[WR_REQ_BIT]), 1);
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("mid_rst");
    exp_q.delete();
    acks_exp = 0;
    wr0 = n_wr;
    rst_n = 1'b1;
    repeat (20) tick();
    check_reset_vals("post_rst");
    frame(VBLANK_LINES);
    chk("t4_no_wr", n_wr - wr0, 0);
    issue_req(ENT_W'($urandom), 100, lat);
    chk("t4_ack_lat_after", lat, 3);
    frame(VBLANK_LINES);
    chk("t4_wr_after", n_wr - wr0, 1);
    chk("t4_drained", exp_q.size(), 0);

    // 4 entries and one long hsync pulse outside vblank
    wr0 = n_wr;
    for (int i = 0; i < 4; i++) begin
      issue_req(ENT_W'($urandom), 100, lat);
      chk("t5_ack_lat", lat, 3);
    end
    hs_line(200, 20);
    chk("t5_hs_wr", n_wr - wr0, HB ? 4 : 0);
    if (!HB) frame(VBLANK_LINES);
    chk("t5_total_wr", n_wr - wr0, 4);
    chk("t5_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_wr_scheduler.md
# osd_wr_scheduler

Sequences CPU-issued OSD write requests into the OSD character/colour RAM write port in the N64 video clock domain. Requests cross from the NIOS II domain via a toggle handshake, are buffered in a small FIFO and released only inside video blanking windows derived from the N64 sync stream. The block sits between the controller's write-vector output and the OSD RAM, and owns that RAM's write port.

## Interface
- FIFO_DEPTH, 8: request buffer entries; power of two, 2..32.
- VBLANK_LINES, 16: number of lines after the nVSYNC falling edge during which writes are released.
- ADDR_W, 11: RAM address width.
- DATA_W, 12: RAM data width.
- N64_CLK_i  in  1  video clock; all logic on its rising edge.
- CTRL_nRST  in  1  reset, asynchronous, active-low.
- nVDSYNC_i  in  1  low = sync nibble valid on VD_*.
- VD_VS_i  in  1  nVSYNC, active low, sampled when !nVDSYNC_i.
- VD_HS_i  in  1  nHSYNC, active low, sampled when !nVDSYNC_i.
- wr_vec_i  in  25  {req_tgl, sel, addr[ADDR_W-1:0], data[DATA_W-1:0]}; held stable by the CPU from its toggle until ack.
- wr_ack_tgl_o  out  1  toggles once per accepted request.
- ram_we_o  out  1  one-cycle write strobe.
- ram_sel_o  out  1  0 = character RAM, 1 = colour RAM.
- ram_addr_o  out  ADDR_W  write address.
- ram_data_o  out  DATA_W  write data.
- fifo_lvl_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- win_open_o  out  1  write window open.

## Operation
- Sync sampling: vs_buf and hs_buf are loaded only when !nVDSYNC_i. Falling edges are detected against a one-cycle delayed copy.
- Request path: req_tgl passes through a 2-flop synchroniser, then edge detection against req_prev.
- A request is taken when synced != req_prev and the FIFO is not full. A take pushes {sel, addr, data}, sets req_prev to the synced value and toggles wr_ack_tgl_o.
- FIFO full: the request stays pending with no ack. This backpressure means the block has no overflow condition.
- Arming: for 3 cycles after reset release, req_prev tracks the synced value and no pushes occur. This suppresses a spurious edge when the CPU toggle is 1.
- States:
  - ST_ACTIVE: window closed. On a vs falling edge go to ST_VBLANK with line_cnt=0.
  - ST_VBLANK: window open. line_cnt increments on each hs falling edge. At line_cnt==VBLANK_LINES-1 plus an hs falling edge, go to ST_ACTIVE. A vs falling edge in this state restarts line_cnt=0.
  - ST_HSYNC: exists only when the feature is enabled; see Configuration.
- Pop: one entry per cycle while win_open and FIFO not empty. Order is strictly FIFO.
- Simultaneous push and pop are allowed: level is unchanged and pointers both advance.
- Pointers wrap modulo FIFO_DEPTH. The level counter is one bit wider than the pointers.

## Timing
- Reset values: wr_ack_tgl_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0, fifo_lvl_o=0, win_open_o=0. State is ST_ACTIVE, FIFO emptied.
- Toggle change to push: 3 cycles (2 sync + 1 edge/push). wr_ack_tgl_o changes in the push cycle's register update.
- Push to ram_we_o: at least 2 cycles (level update, then registered pop outputs). The pop decision uses the registered empty flag, so an empty FIFO plus a push never pops in the same cycle.
- win_open_o is registered: high the cycle after the edge that opens the window, low the cycle after the edge that closes it. The last pop can occur in the closing cycle.
- ram_we_o is high for exactly 1 cycle per entry; ram_* outputs are held between strobes.
- Reset mid-window: any in-flight write is dropped and all buffered entries are lost; the CPU re-issues requests.

## Configuration
- OSD_HBLANK_WR_EN defined:
  - ST_HSYNC is added. ST_ACTIVE goes to ST_HSYNC on an hs falling edge; ST_HSYNC returns to ST_ACTIVE when hs_buf goes high.
  - The window is open in ST_HSYNC.
  - A vs falling edge in ST_HSYNC goes to ST_VBLANK.
- OSD_HBLANK_WR_EN undefined: writes are released during vertical blanking only; ST_HSYNC logic is absent.

## Structure
- The wr_vec field positions (req_tgl, sel, addr, data slices) and the state encodings belong in the shared config header used by the controller.
- One sub-module: osd_wr_fifo, a synchronous FIFO with registered full/empty and a level output.

## Test plan
- 1 request, window closed: ack 3 cycles after the toggle, fifo_lvl_o=1, no ram_we_o until a vs falling edge. Then exactly one strobe with sel/addr/data = the request values (e.g. addr=11'h12A, data=12'h0F3).
- 9 back-to-back requests with the window closed: 8 acked, the 9th un-acked until the vblank window pops one entry, then acked.
- VBLANK_LINES=16: the window closes after the 16th hs falling edge. 20 buffered entries (across refills) are written only while win_open_o=1, in order.
- Reset asserted while fifo_lvl_o=5 and CPU toggle=1: after release, outputs are at reset values and there is no spurious ack or push.
- With OSD_HBLANK_WR_EN, 4 entries and 200-cycle hs pulses: all 4 are written during the first hsync pulse. Without the macro: 0 writes until vsync.
